// File: rtl/aq_djpeg_idctb_rdctl.sv
// Read-side sequencer for the IDCT transpose buffer.
//
// Waits for the buffer to report a complete bank, then issues the 32 read
// addresses of that bank. The buffer has a one-cycle registered read, and its
// output lane mux follows the live address instead of the address that was
// read. This block delivers each word through a small output FIFO with a
// valid/ready handshake. Issue is gated by credits, so the FIFO cannot
// overflow.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   DataInit         per-image restart, same effect as reset
//   BufEnable        buffer holds a complete bank
//   BufRead          read strobe (combinational from state and credit)
//   BufAddress       registered read index {page[2:0], count[1:0]}
//   BufDataA/B       buffer read lanes, valid one cycle after the issue
//   OutValid/Ready   handshake for the FIFO head
//   OutPage/Count    address of the head word
//   OutA/OutB        lane-corrected data of the head word
//   OutLast          head word is address 31
//   Busy             sequencing, a read in flight, or FIFO not empty
//   BlockCount       blocks fully issued since reset/DataInit
module aq_djpeg_idctb_rdctl #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          DataInit,
    input  logic          BufEnable,
    output logic          BufRead,
    output logic [4:0]    BufAddress,
    input  logic [DW-1:0] BufDataA,
    input  logic [DW-1:0] BufDataB,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [2:0]    OutPage,
    output logic [1:0]    OutCount,
    output logic [DW-1:0] OutA,
    output logic [DW-1:0] OutB,
    output logic          OutLast,
    output logic          Busy,
    output logic [15:0]   BlockCount
);

    // FIFO entry: {addr[4:0], last, lane A, lane B}
    localparam int EW = 6 + 2 * DW;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic [15:0]        blk_q, blk_d;
    logic               issue;

    // read pipeline: the word issued last cycle is on the buffer lanes now
    logic               inflight_q;
    logic [4:0]         addr_p;
    logic               a4_p;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW+1:0] occupancy;
    logic               credit, push, pop, swap, clear;
    logic [DW-1:0]      lane_a, lane_b;
    logic [EW-1:0]      wr_entry, head;

    assign clear = !rst || DataInit;

    // The in-flight word already owns a FIFO slot.
    assign occupancy = {1'b0, count_q} + {{(FIFO_AW + 1){1'b0}}, inflight_q};
    assign credit    = occupancy < (FIFO_AW + 2)'(FIFO_DEPTH);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (BufEnable) state_d = READ;
            end
            READ: begin
                if (credit) begin
                    issue = 1'b1;
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        state_d = IDLE;
                        blk_d   = blk_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BufRead    = issue;
    assign BufAddress = idx_q;
    assign BlockCount = blk_q;

    // The buffer's lane mux follows the live address bit 4. When that bit
    // differs from the bit of the word being returned, the lanes are swapped.
    assign swap     = BufAddress[4] != a4_p;
    assign lane_a   = swap ? BufDataB : BufDataA;
    assign lane_b   = swap ? BufDataA : BufDataB;
    assign wr_entry = {addr_p, (addr_p == 5'd31), lane_a, lane_b};

    assign push = inflight_q;
    assign pop  = OutValid && OutReady;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            blk_q      <= '0;
            inflight_q <= 1'b0;
            addr_p     <= '0;
            a4_p       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            blk_q      <= blk_d;
            inflight_q <= issue;
            if (issue) begin
                addr_p <= idx_q;
                a4_p   <= idx_q[4];
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; an empty FIFO masks the head fields below.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_q] <= wr_entry;
    end

    assign head     = mem[rd_ptr_q];
    assign OutValid = count_q != '0;
    assign {OutPage, OutCount, OutLast, OutA, OutB} = OutValid ? head : '0;

    assign Busy = (state_q != IDLE) || inflight_q || (count_q != '0);

endmodule

// File: tb/tb_aq_djpeg_idctb_rdctl.sv
module tb_aq_djpeg_idctb_rdctl;

    logic        clk;
    logic        rst;
    logic        DataInit;
    logic        BufEnable;
    logic        BufRead;
    logic [4:0]  BufAddress;
    logic [15:0] BufDataA;
    logic [15:0] BufDataB;
    logic        OutValid;
    logic        OutReady;
    logic [2:0]  OutPage;
    logic [1:0]  OutCount;
    logic [15:0] OutA;
    logic [15:0] OutB;
    logic        OutLast;
    logic        Busy;
    logic [15:0] BlockCount;

    aq_djpeg_idctb_rdctl #(
        .DW(16),
        .FIFO_DEPTH(4),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .DataInit(DataInit),
        .BufEnable(BufEnable),
        .BufRead(BufRead),
        .BufAddress(BufAddress),
        .BufDataA(BufDataA),
        .BufDataB(BufDataB),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .OutPage(OutPage),
        .OutCount(OutCount),
        .OutA(OutA),
        .OutB(OutB),
        .OutLast(OutLast),
        .Busy(Busy),
        .BlockCount(BlockCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: bank b word i holds A=0x1000+b*256+i, B=0x2000+b*256+i.
    // Words with address bit 4 set are stored lane-swapped, and the output
    // mux follows the live address. This reproduces the swap that the
    // controller must undo.
    int          wbank;
    int          rbank;
    logic [15:0] l0, l1;

    function automatic logic [15:0] va(int b, int i);
        return 16'(32'h1000 + b * 256 + i);
    endfunction

    function automatic logic [15:0] vb(int b, int i);
        return 16'(32'h2000 + b * 256 + i);
    endfunction

    always @(posedge clk) begin
        if (!rst || DataInit) rbank <= 0;
        else if (BufRead && BufAddress == 5'd31) rbank <= rbank + 1;
        if (BufRead) begin
            l0 <= BufAddress[4] ? vb(rbank, int'(BufAddress)) : va(rbank, int'(BufAddress));
            l1 <= BufAddress[4] ? va(rbank, int'(BufAddress)) : vb(rbank, int'(BufAddress));
        end
    end

    assign BufEnable = (wbank != rbank);
    assign BufDataA  = BufAddress[4] ? l1 : l0;
    assign BufDataB  = BufAddress[4] ? l0 : l1;

    int nchk;
    int nerr;
    int cyc;
    int exp_idx;
    int exp_bank;
    int issued;
    int popped;
    int reads31;
    int lasts;
    int last31_cyc;
    int gap0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs at the negedge: the inputs seen here are the ones the next
    // posedge samples.
    task automatic monitor();
        if (!rst || DataInit) begin
            exp_idx  = 0;
            exp_bank = 0;
            issued   = 0;
            popped   = 0;
        end else begin
            if (BufRead) begin
                issued++;
                if (BufAddress == 5'd31) begin
                    reads31++;
                    last31_cyc = cyc;
                end
                if (BufAddress == 5'd0) gap0 = cyc - last31_cyc;
            end
            if (OutValid && OutReady) begin
                popped++;
                chk("beat_page",  {29'd0, OutPage},  32'(exp_idx / 4));
                chk("beat_count", {30'd0, OutCount}, 32'(exp_idx % 4));
                chk("beat_a",     {16'd0, OutA},     {16'd0, va(exp_bank, exp_idx)});
                chk("beat_b",     {16'd0, OutB},     {16'd0, vb(exp_bank, exp_idx)});
                chk("beat_last",  {31'd0, OutLast},  {31'd0, exp_idx == 31});
                if (OutLast) lasts++;
                exp_idx++;
                if (exp_idx == 32) begin
                    exp_idx = 0;
                    exp_bank++;
                end
            end
            chk("fifo_bound", {31'd0, (issued - popped) <= 4}, 32'd1);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    logic        first_seen;
    int          bubbles;
    logic        stalled;
    logic        hit;

    initial begin
        nchk = 0; nerr = 0; cyc = 0;
        exp_idx = 0; exp_bank = 0; issued = 0; popped = 0;
        reads31 = 0; lasts = 0; last31_cyc = 0; gap0 = 0;
        rst = 1'b0; DataInit = 1'b0; OutReady = 1'b1; wbank = 0;
        step();
        step();
        chk("rst_valid", {31'd0, OutValid},   32'd0);
        chk("rst_read",  {31'd0, BufRead},    32'd0);
        chk("rst_addr",  {27'd0, BufAddress}, 32'd0);
        chk("rst_blk",   {16'd0, BlockCount}, 32'd0);
        chk("rst_busy",  {31'd0, Busy},       32'd0);
        chk("rst_last",  {31'd0, OutLast},    32'd0);
        chk("rst_outa",  {16'd0, OutA},       32'd0);
        rst = 1'b1;

        // single block, consumer always ready
        wbank = 1;
        step();
        chk("first_issue_read", {31'd0, BufRead},    32'd1);
        chk("first_issue_addr", {27'd0, BufAddress}, 32'd0);
        first_seen = 1'b0;
        bubbles = 0;
        for (int unsigned t = 0; t < 200 && exp_bank == 0; t++) begin
            step();
            if (OutValid) first_seen = 1'b1;
            else if (first_seen && exp_bank == 0) bubbles++;
        end
        chk("b1_done",    32'(exp_bank),       32'd1);
        chk("b1_lasts",   32'(lasts),          32'd1);
        chk("b1_reads31", 32'(reads31),        32'd1);
        chk("b1_blk",     {16'd0, BlockCount}, 32'd1);
        chk("b1_bubbles", 32'(bubbles),        32'd0);
        chk("b1_busy",    {31'd0, Busy},       32'd0);

        // backpressure after two beats for ten cycles
        wbank = 2;
        stalled = 1'b0;
        for (int unsigned t = 0; t < 400 && exp_bank == 1; t++) begin
            step();
            if (!stalled && exp_idx == 2) begin
                stalled = 1'b1;
                OutReady = 1'b0;
                for (int unsigned s = 0; s < 10; s++) begin
                    step();
                    chk("bp_valid", {31'd0, OutValid},           32'd1);
                    chk("bp_head",  {27'd0, OutPage, OutCount},  32'd2);
                    chk("bp_a",     {16'd0, OutA},               32'h1102);
                    chk("bp_b",     {16'd0, OutB},               32'h2102);
                    if (s >= 1) chk("bp_noread", {31'd0, BufRead}, 32'd0);
                end
                chk("bp_addr_held", {27'd0, BufAddress}, 32'd6);
                OutReady = 1'b1;
            end
        end
        chk("b2_stalled", {31'd0, stalled},    32'd1);
        chk("b2_done",    32'(exp_bank),       32'd2);
        chk("b2_blk",     {16'd0, BlockCount}, 32'd2);

        // two banks queued back to back: one bubble between addr 31 and addr 0
        wbank = 4;
        for (int unsigned t = 0; t < 400 && exp_bank < 4; t++) step();
        chk("b3_done", 32'(exp_bank),       32'd4);
        chk("b3_gap",  32'(gap0),           32'd2);
        chk("b3_blk",  {16'd0, BlockCount}, 32'd4);

        // eight banks with random consumer readiness
        wbank = 12;
        for (int unsigned t = 0; t < 4000 && exp_bank < 12; t++) begin
            step();
            OutReady = ($urandom_range(0, 1) == 1);
        end
        OutReady = 1'b1;
        chk("rnd_done", 32'(exp_bank),       32'd12);
        chk("rnd_blk",  {16'd0, BlockCount}, 32'd12);

        // DataInit in the middle of a block, at index 12
        wbank = 13;
        hit = 1'b0;
        for (int unsigned t = 0; t < 100 && !hit; t++) begin
            step();
            if (BufRead && BufAddress == 5'd12) hit = 1'b1;
        end
        chk("di_reached", {31'd0, hit}, 32'd1);
        DataInit = 1'b1;
        wbank = 0;
        step();
        chk("di_valid", {31'd0, OutValid},   32'd0);
        chk("di_read",  {31'd0, BufRead},    32'd0);
        chk("di_addr",  {27'd0, BufAddress}, 32'd0);
        chk("di_blk",   {16'd0, BlockCount}, 32'd0);
        chk("di_busy",  {31'd0, Busy},       32'd0);
        DataInit = 1'b0;
        wbank = 1;
        for (int unsigned t = 0; t < 200 && exp_bank == 0; t++) step();
        chk("di_restart_done", 32'(exp_bank),       32'd1);
        chk("di_restart_blk",  {16'd0, BlockCount}, 32'd1);

        // synchronous reset asserted between edges with a full FIFO
        wbank = 2;
        OutReady = 1'b0;
        for (int unsigned t = 0; t < 8; t++) step();
        chk("pre_valid", {31'd0, OutValid},   32'd1);
        chk("pre_addr",  {27'd0, BufAddress}, 32'd4);
        chk("pre_read",  {31'd0, BufRead},    32'd0);
        rst = 1'b0;
        #2;
        chk("mid_valid", {31'd0, OutValid},   32'd1);
        chk("mid_addr",  {27'd0, BufAddress}, 32'd4);
        chk("mid_a",     {16'd0, OutA},       32'h1100);
        chk("mid_blk",   {16'd0, BlockCount}, 32'd1);
        chk("mid_busy",  {31'd0, Busy},       32'd1);
        wbank = 0;
        step();
        chk("sr_valid", {31'd0, OutValid},          32'd0);
        chk("sr_read",  {31'd0, BufRead},           32'd0);
        chk("sr_addr",  {27'd0, BufAddress},        32'd0);
        chk("sr_blk",   {16'd0, BlockCount},        32'd0);
        chk("sr_busy",  {31'd0, Busy},              32'd0);
        chk("sr_last",  {31'd0, OutLast},           32'd0);
        chk("sr_head",  {27'd0, OutPage, OutCount}, 32'd0);
        chk("sr_a",     {16'd0, OutA},              32'd0);
        chk("sr_b",     {16'd0, OutB},              32'd0);
        rst = 1'b1;
        OutReady = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
